// File: rtl/seq_bin_to_bcd.sv
// seq_bin_to_bcd: sequential shift-add-3 binary to two-digit BCD converter with overflow flag
//   clock      in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   bin_in     in   32-bit value, low IN_WIDTH bits converted, upper bits feed overflow
//   in_valid   in   conversion request, accepted with in_ready
//   in_ready   out  high only while idle
//   dig_h      out  BCD tens digit
//   dig_l      out  BCD units digit
//   ovf        out  value does not fit in two decimal digits
//   out_valid  out  one-cycle pulse when dig_h/dig_l/ovf update
//   busy       out  conversion in progress
module seq_bin_to_bcd #(
   parameter int IN_WIDTH = 8
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] bin_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [3:0]  dig_h,
   output logic [3:0]  dig_l,
   output logic        ovf,
   output logic        out_valid,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state, state_nxt;
   logic [IN_WIDTH-1:0] bin_reg;
   logic [19:0] bcd, bcd_adj;
   logic [4:0] cnt;
   logic hi_nz, accept;
   assign in_ready = state == IDLE;
   assign busy = state != IDLE;
   assign accept = in_valid & in_ready;
   for (genvar i = 0; i < 5; i++) begin : g_adj
      assign bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
   end
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = IDLE;
      if (state == IDLE) state_nxt = accept ? SHIFT : IDLE;
      else if (state == SHIFT) state_nxt = cnt == 5'(IN_WIDTH - 1) ? DONE : SHIFT;
   end
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         bin_reg <= '0;
         bcd <= '0;
         cnt <= '0;
         hi_nz <= 1'b0;
         dig_h <= '0;
         dig_l <= '0;
         ovf <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= state == DONE;
         if (accept) begin
            bin_reg <= bin_in[IN_WIDTH-1:0];
            hi_nz <= |bin_in[31:IN_WIDTH];
            bcd <= '0;
            cnt <= '0;
         end
         if (state == SHIFT) begin
            {bcd, bin_reg} <= {bcd_adj, bin_reg} << 1;
            cnt <= cnt + 5'd1;
         end
         if (state == DONE) begin
            dig_l <= bcd[3:0];
            dig_h <= bcd[7:4];
            ovf <= hi_nz | (|bcd[19:8]);
         end
      end
endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// tb_seq_bin_to_bcd: directed self-checking bench for seq_bin_to_bcd with IN_WIDTH=8
module tb_seq_bin_to_bcd;
   logic clock = 1'b0;
   logic resetn;
   logic [31:0] bin_in;
   logic in_valid;
   logic in_ready, ovf, out_valid, busy;
   logic [3:0] dig_h, dig_l;
   int n_chk = 0;
   int n_err = 0;
   logic [3:0] last_h = 4'd0;
   logic [3:0] last_l = 4'd0;
   logic last_o = 1'b0;
   seq_bin_to_bcd #(.IN_WIDTH(8)) dut (
      .clock(clock), .resetn(resetn), .bin_in(bin_in), .in_valid(in_valid),
      .in_ready(in_ready), .dig_h(dig_h), .dig_l(dig_l), .ovf(ovf),
      .out_valid(out_valid), .busy(busy)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic convert(input logic [31:0] v, input logic [3:0] eh, input logic [3:0] el,
                          input logic eo, input string tag);
      int cyc;
      logic got;
      @(negedge clock);
      bin_in = v;
      in_valid = 1'b1;
      cyc = 0;
      got = 1'b0;
      while (cyc < 40 && !got) begin
         @(negedge clock);
         cyc++;
         if (cyc == 1) begin
            in_valid = 1'b0;
            chk({tag, " busy"}, busy, 1);
         end
         if (cyc == 4) begin
            chk({tag, " hold_h"}, dig_h, last_h);
            chk({tag, " hold_l"}, dig_l, last_l);
            chk({tag, " hold_ovf"}, ovf, last_o);
            chk({tag, " not_ready"}, in_ready, 0);
         end
         got = out_valid;
      end
      chk({tag, " pulse_seen"}, got, 1);
      chk({tag, " latency"}, cyc - 1, 9);
      chk({tag, " dig_h"}, dig_h, eh);
      chk({tag, " dig_l"}, dig_l, el);
      chk({tag, " ovf"}, ovf, eo);
      @(negedge clock);
      chk({tag, " single_pulse"}, out_valid, 0);
      last_h = eh;
      last_l = el;
      last_o = eo;
   endtask
   initial begin
      int pulses, p1, p2;
      logic [3:0] h1, l1, h2, l2;
      resetn = 1'b0;
      in_valid = 1'b0;
      bin_in = '0;
      repeat (3) @(negedge clock);
      chk("rst dig_h", dig_h, 0);
      chk("rst dig_l", dig_l, 0);
      chk("rst ovf", ovf, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst busy", busy, 0);
      chk("rst in_ready", in_ready, 1);
      resetn = 1'b1;
      pulses = 0;
      repeat (20) begin
         @(negedge clock);
         if (out_valid) pulses++;
      end
      chk("idle no_pulse", pulses, 0);
      chk("idle in_ready", in_ready, 1);
      convert(32'd59, 4'd5, 4'd9, 1'b0, "v59");
      convert(32'd0, 4'd0, 4'd0, 1'b0, "v0");
      convert(32'd99, 4'd9, 4'd9, 1'b0, "v99");
      convert(32'd100, 4'd0, 4'd0, 1'b1, "v100");
      convert(32'd255, 4'd5, 4'd5, 1'b1, "v255");
      convert(32'h0000_0105, 4'd0, 4'd5, 1'b1, "v105");
      @(negedge clock);
      bin_in = 32'd42;
      in_valid = 1'b1;
      p1 = 0;
      p2 = 0;
      h1 = 4'd0; l1 = 4'd0; h2 = 4'd0; l2 = 4'd0;
      for (int c = 1; c <= 40 && p2 == 0; c++) begin
         @(negedge clock);
         if (c == 3) bin_in = 32'd17;
         if (out_valid) begin
            if (p1 == 0) begin
               p1 = c;
               h1 = dig_h;
               l1 = dig_l;
            end else begin
               p2 = c;
               h2 = dig_h;
               l2 = dig_l;
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      chk("held first_latency", p1, 10);
      chk("held first_h", h1, 4);
      chk("held first_l", l1, 2);
      chk("held second_h", h2, 1);
      chk("held second_l", l2, 7);
      chk("held spacing", p2 - p1, 10);
      last_h = 4'd1;
      last_l = 4'd7;
      last_o = 1'b0;
      repeat (2) @(negedge clock);
      chk("held idle_again", in_ready, 1);
      convert(32'd73, 4'd7, 4'd3, 1'b0, "v73");
      @(negedge clock);
      bin_in = 32'd200;
      in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("abort busy_before", busy, 1);
      chk("abort hold_h", dig_h, 7);
      resetn = 1'b0;
      #1;
      chk("abort dig_h", dig_h, 0);
      chk("abort dig_l", dig_l, 0);
      chk("abort ovf", ovf, 0);
      chk("abort busy", busy, 0);
      chk("abort in_ready", in_ready, 1);
      @(negedge clock);
      resetn = 1'b1;
      pulses = 0;
      repeat (15) begin
         @(negedge clock);
         if (out_valid) pulses++;
      end
      chk("abort no_pulse", pulses, 0);
      chk("abort ready_after", in_ready, 1);
      last_h = 4'd0;
      last_l = 4'd0;
      last_o = 1'b0;
      convert(32'd64, 4'd6, 4'd4, 1'b0, "v64");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
